// File: rtl/sonata_pkg.sv
// rtl/sonata_pkg.sv - CHERI error channel ordering and report FSM states
package sonata_pkg;

  localparam int CheriErrWidth = 9;

  typedef enum logic [3:0] {
    Bounds              = 4'd0,
    Tag                 = 4'd1,
    Seal                = 4'd2,
    PermitExecute       = 4'd3,
    PermitLoad          = 4'd4,
    PermitStore         = 4'd5,
    PermitStoreCap      = 4'd6,
    PermitStoreLocalCap = 4'd7,
    PermitAccSysRegs    = 4'd8
  } cheri_err_e;

  typedef enum logic {
    RptIdle    = 1'b0,
    RptPresent = 1'b1
  } rpt_state_e;

endpackage

// File: rtl/cheri_err_chan.sv
// rtl/cheri_err_chan.sv - one error channel: edge detect, sticky, saturating count, first-rise stamp
module cheri_err_chan #(
  parameter int CntWidth = 16,
  parameter int TsWidth  = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                err_i,
  input  logic                clear_i,
  input  logic [TsWidth-1:0]  ts_i,
  input  logic                pop_i,
  output logic                sticky_o,
  output logic [CntWidth-1:0] count_o,
  output logic [TsWidth-1:0]  ts_o,
  output logic                pending_o
);

  logic                err_q;
  logic                sticky_q, sticky_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic [TsWidth-1:0]  ts_q, ts_d;
  logic                pending_q, pending_d;
  logic                rise;
  logic                first;

  assign rise  = err_i & ~err_q;
  // A clear in the same cycle makes this rise the first one again.
  assign first = rise & (~sticky_q | clear_i);

  always_comb begin
    sticky_d  = sticky_q;
    count_d   = count_q;
    ts_d      = ts_q;
    pending_d = pending_q;
    if (pop_i) pending_d = 1'b0;
    if (clear_i) begin
      sticky_d  = 1'b0;
      count_d   = '0;
      pending_d = 1'b0;
    end
    if (rise) begin
      sticky_d = 1'b1;
      if (clear_i)         count_d = CntWidth'(1);
      else if (~&count_q)  count_d = count_q + CntWidth'(1);
    end
    if (first) begin
      ts_d      = ts_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      count_q   <= '0;
      ts_q      <= '0;
      pending_q <= 1'b0;
    end else begin
      err_q     <= err_i;
      sticky_q  <= sticky_d;
      count_q   <= count_d;
      ts_q      <= ts_d;
      pending_q <= pending_d;
    end
  end

  assign sticky_o  = sticky_q;
  assign count_o   = count_q;
  assign ts_o      = ts_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/cheri_err_monitor.sv
// rtl/cheri_err_monitor.sv - CHERI error monitor: per-channel trackers, timestamp, report stream
module cheri_err_monitor
  import sonata_pkg::*;
#(
  parameter int  ErrWidth = CheriErrWidth,
  parameter int  CntWidth = 16,
  parameter int  TsWidth  = 32,
  localparam int IdxWidth = (ErrWidth > 1) ? $clog2(ErrWidth) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ErrWidth-1:0]          err_i,
  input  logic [ErrWidth-1:0]          clear_i,
  output logic [ErrWidth-1:0]          sticky_o,
  output logic                         any_err_o,
  output logic [ErrWidth*CntWidth-1:0] count_o,
  output logic                         report_valid_o,
  input  logic                         report_ready_i,
  output logic [IdxWidth-1:0]          report_idx_o,
  output logic [TsWidth-1:0]           report_time_o
);

  logic [TsWidth-1:0]  ts_q;
  logic [TsWidth-1:0]  chan_ts [ErrWidth];
  logic [ErrWidth-1:0] pending;
  logic [ErrWidth-1:0] pop;
  logic [IdxWidth-1:0] sel_idx;
  logic [TsWidth-1:0]  sel_ts;

  rpt_state_e          state_q, state_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic [TsWidth-1:0]  time_q, time_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_q + TsWidth'(1);
  end

  for (genvar e = 0; e < ErrWidth; e++) begin : g_chan
    cheri_err_chan #(
      .CntWidth(CntWidth),
      .TsWidth (TsWidth)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .err_i    (err_i[e]),
      .clear_i  (clear_i[e]),
      .ts_i     (ts_q),
      .pop_i    (pop[e]),
      .sticky_o (sticky_o[e]),
      .count_o  (count_o[e*CntWidth +: CntWidth]),
      .ts_o     (chan_ts[e]),
      .pending_o(pending[e])
    );
  end

  assign any_err_o = |sticky_o;

  // Scan downwards so the lowest pending index is the one left selected.
  always_comb begin
    sel_idx = '0;
    sel_ts  = '0;
    for (int i = ErrWidth - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx = IdxWidth'(i);
        sel_ts  = chan_ts[i];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    time_d         = time_q;
    pop            = '0;
    report_valid_o = 1'b0;
    case (state_q)
      RptIdle: begin
        if (|pending) begin
          idx_d   = sel_idx;
          time_d  = sel_ts;
          state_d = RptPresent;
        end
      end
      RptPresent: begin
        report_valid_o = 1'b1;
        if (report_ready_i) begin
          pop     = ErrWidth'(1) << idx_q;
          state_d = RptIdle;
        end
      end
      default: state_d = RptIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RptIdle;
      idx_q   <= '0;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      time_q  <= time_d;
    end
  end

  assign report_idx_o  = idx_q;
  assign report_time_o = time_q;

endmodule
